dcache_responder: RTL and testbench

//  Memory-side responder for the MEM stage's data port: services dmemREN/dmemWEN, returns dhit/dmemload.

---
 rtl/cpu_types_pkg.sv | 36 +++
 rtl/dcache_responder_if.sv | 18 +
 rtl/dcache_responder_array.sv | 23 ++
 rtl/dcache_responder.sv | 91 +++++++++
 tb/tb_dcache_responder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word/RAM types plus data-cache state, address and line layouts.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    localparam int SETS  = 16;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {IDLE, WB, ALLOC} dcache_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [1:0]       bytoff;
    } dcache_addr_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
        word_t            data;
    } dcache_line_t;

    function automatic logic [TAG_W-1:0] tagOf(word_t a);
        dcache_addr_t f;
        f = a;
        return f.tag;
    endfunction

    function automatic logic [IDX_W-1:0] idxOf(word_t a);
        dcache_addr_t f;
        f = a;
        return f.idx;
    endfunction
endpackage

// File: rtl/dcache_responder_if.sv
// dcache_responder_if: MEM-stage data port and RAM port of the data cache in one bundle.
interface dcache_responder_if;
    import cpu_types_pkg::*;
    logic      dmemREN, dmemWEN, dhit;
    word_t     dmemaddr, dmemstore, dmemload;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ramstate,
        input  dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore
    );
    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ramstate,
        output dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/dcache_responder_array.sv
// dcache_array: SETS lines of {valid,dirty,tag,data}; async read, sync write, async clear.
module dcache_array
    import cpu_types_pkg::*;
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic [IDX_W-1:0] idx,
    input  logic             we,
    input  dcache_line_t     wLine,
    output dcache_line_t     rLine
);
    dcache_line_t lines [SETS];

    assign rLine = lines[idx];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) lines[i] <= '0;
        end else if (we) begin
            lines[idx] <= wLine;
        end
    end
endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-back write-allocate data cache between MEM stage and RAM.
// Defining DCACHE_STATS_EN adds hit_count/miss_count outputs.
module dcache_responder
    import cpu_types_pkg::*;
(
    input logic CLK,
    input logic nRST,
    dcache_responder_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output word_t hit_count,
    output word_t miss_count
`endif
);
    dcache_state_t    state, next;
    dcache_line_t     line, wLine;
    logic             we, req, hit;
    logic [TAG_W-1:0] aTag;
    logic [IDX_W-1:0] aIdx;

    assign aTag = tagOf(bus.dmemaddr);
    assign aIdx = idxOf(bus.dmemaddr);
    assign req  = bus.dmemREN || bus.dmemWEN;
    assign hit  = line.valid && line.tag == aTag;
    assign bus.dmemload = line.data;

    dcache_array u_array (
        .CLK   (CLK),
        .nRST  (nRST),
        .idx   (aIdx),
        .we    (we),
        .wLine (wLine),
        .rLine (line)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next;
    end

    // Victim and fill both use the index of the current dmemaddr, which MEM holds while stalled.
    always_comb begin
        next         = state;
        we           = 1'b0;
        wLine        = line;
        bus.dhit     = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state)
            IDLE: if (req) begin
                if (hit) begin
                    bus.dhit = 1'b1;
                    we       = bus.dmemWEN;
                    wLine    = '{valid: 1'b1, dirty: 1'b1, tag: aTag, data: bus.dmemstore};
                end else begin
                    next = (line.valid && line.dirty) ? WB : ALLOC;
                end
            end
            WB: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = {line.tag, aIdx, 2'b00};
                bus.ramstore = line.data;
                wLine.dirty  = 1'b0;
                we           = bus.ramstate == ACCESS;
                next         = we ? ALLOC : WB;
            end
            ALLOC: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = {bus.dmemaddr[31:2], 2'b00};
                wLine       = '{valid: 1'b1, dirty: 1'b0, tag: aTag, data: bus.ramload};
                we          = bus.ramstate == ACCESS;
                next        = we ? IDLE : ALLOC;
            end
            default: next = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && req && hit)  hit_count  <= hit_count + 32'd1;
            if (state == IDLE && req && !hit) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: vector table plus scoreboard against a latency-modelled RAM.
module tb_dcache_responder;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    dcache_responder_if bus();
`ifdef DCACHE_STATS_EN
    word_t hit_count, miss_count;
`endif

    dcache_responder dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // RAM model: ramLat BUSY cycles then one ACCESS cycle per request
    word_t mem [word_t];
    int    ramLat = 2;
    int    ramCnt = 0;

    function automatic word_t rd(word_t a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    always_comb bus.ramstate = !(bus.ramREN || bus.ramWEN) ? FREE :
                               (ramCnt >= ramLat ? ACCESS : BUSY);

    always @(posedge CLK) begin
        ramCnt <= ((bus.ramREN || bus.ramWEN) && bus.ramstate != ACCESS) ? ramCnt + 1 : 0;
        if (bus.ramWEN && bus.ramstate == ACCESS) mem[bus.ramaddr] = bus.ramstore;
    end

    always @(negedge CLK) bus.ramload <= rd(bus.ramaddr);

    int    vectors = 0;
    int    miscompares = 0;
    int    overlaps = 0;
    word_t sb [$];

    task automatic check(input string name, input word_t act, input word_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic doReq(input logic ren, input logic wen, input word_t a, input word_t d,
                         input word_t expLoad, output int cyc, output int rc, output int wc,
                         output word_t wbA, output word_t wbD, output word_t alA);
        @(negedge CLK);
        bus.dmemREN = ren;
        bus.dmemWEN = wen;
        bus.dmemaddr = a;
        bus.dmemstore = d;
        if (ren && !wen) sb.push_back(expLoad);
        cyc = 0; rc = 0; wc = 0; wbA = '0; wbD = '0; alA = '0;
        #1;
        while (1) begin
            if (bus.ramREN) begin rc++; alA = bus.ramaddr; end
            if (bus.ramWEN) begin
                wc++;
                if (wc == 1) begin wbA = bus.ramaddr; wbD = bus.ramstore; end
            end
            if (bus.ramREN && bus.ramWEN) overlaps++;
            if (bus.dhit || cyc >= 40) break;
            @(negedge CLK);
            #1;
            cyc++;
        end
        check("dhit_seen", {31'b0, bus.dhit}, 32'd1);
        if (bus.dhit && ren && !wen) begin
            if (sb.size() == 0) check("sb_nonempty", 32'd0, 32'd1);
            else check("dmemload", bus.dmemload, sb.pop_front());
        end
        @(posedge CLK);
        #1;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        #1;
        check("dhit_single", {31'b0, bus.dhit}, 32'd0);
    endtask

    typedef struct {
        logic  ren, wen;
        word_t addr, wdata, expLoad;
        int    expCyc, expRen, expWen;
        word_t expWbA, expWbD, expAl;
    } vec_t;

    vec_t vt [10];

    initial begin
        int    cyc, rc, wc, n;
        word_t wbA, wbD, alA;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        bus.dmemaddr = '0;
        bus.dmemstore = '0;
        mem[32'h40]  = 32'hDEAD_BEEF;
        mem[32'h440] = 32'hCAFE_0440;
        mem[32'h80]  = 32'h0000_0005;

        vt[0] = '{1, 0, 32'h40,  0,          32'hDEAD_BEEF, 4, 3, 0, 0,     0,            32'h40};
        vt[1] = '{1, 0, 32'h40,  0,          32'hDEAD_BEEF, 0, 0, 0, 0,     0,            0};
        vt[2] = '{0, 1, 32'h40,  32'h1234_5678, 0,          0, 0, 0, 0,     0,            0};
        vt[3] = '{1, 0, 32'h440, 0,          32'hCAFE_0440, 7, 3, 3, 32'h40, 32'h1234_5678, 32'h440};
        vt[4] = '{1, 0, 32'h40,  0,          32'h1234_5678, 4, 3, 0, 0,     0,            32'h40};
        vt[5] = '{1, 0, 32'h80,  0,          32'h0000_0005, 4, 3, 0, 0,     0,            32'h80};
        vt[6] = '{1, 1, 32'h80,  32'hA5,     0,             0, 0, 0, 0,     0,            0};
        vt[7] = '{1, 0, 32'h80,  0,          32'hA5,        0, 0, 0, 0,     0,            0};
        vt[8] = '{1, 0, 32'h84,  0,          32'h5A5A_0084, 4, 3, 0, 0,     0,            32'h84};
        vt[9] = '{1, 0, 32'h40,  0,          32'h1234_5678, 7, 3, 3, 32'h80, 32'hA5,       32'h40};

        #1;
        check("rst_dhit",     {31'b0, bus.dhit},   32'd0);
        check("rst_dmemload", bus.dmemload,        32'd0);
        check("rst_ramREN",   {31'b0, bus.ramREN}, 32'd0);
        check("rst_ramWEN",   {31'b0, bus.ramWEN}, 32'd0);
        check("rst_ramaddr",  bus.ramaddr,         32'd0);
        check("rst_ramstore", bus.ramstore,        32'd0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 10; i++) begin
            doReq(vt[i].ren, vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].expLoad,
                  cyc, rc, wc, wbA, wbD, alA);
            check($sformatf("v%0d_latency", i), cyc, vt[i].expCyc);
            check($sformatf("v%0d_renCycles", i), rc, vt[i].expRen);
            check($sformatf("v%0d_wenCycles", i), wc, vt[i].expWen);
            if (vt[i].expWen > 0) begin
                check($sformatf("v%0d_wbAddr", i), wbA, vt[i].expWbA);
                check($sformatf("v%0d_wbData", i), wbD, vt[i].expWbD);
            end
            if (vt[i].expRen > 0) check($sformatf("v%0d_allocAddr", i), alA, vt[i].expAl);
        end

        // Flush mid-ALLOC: fill completes silently, then the address hits
        @(negedge CLK);
        bus.dmemREN = 1'b1;
        bus.dmemaddr = 32'h100;
        n = 0;
        do begin @(negedge CLK); #1; n++; end while (!bus.ramREN && n < 10);
        check("flush_alloc_start", {31'b0, bus.ramREN}, 32'd1);
        bus.dmemREN = 1'b0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            #1;
            if (bus.dhit) n++;
        end
        check("flush_no_dhit", n, 0);
        check("flush_idle_ramREN", {31'b0, bus.ramREN}, 32'd0);
        doReq(1, 0, 32'h100, 0, 32'h5A5A_0100, cyc, rc, wc, wbA, wbD, alA);
        check("flush_refetch_latency", cyc, 0);
        check("flush_refetch_ren", rc, 0);

        // Reset during write-back of a dirty line
        doReq(0, 1, 32'h100, 32'h77, 0, cyc, rc, wc, wbA, wbD, alA);
        check("dirty_store_latency", cyc, 0);
        @(negedge CLK);
        bus.dmemREN = 1'b1;
        bus.dmemaddr = 32'h500;
        n = 0;
        do begin @(negedge CLK); #1; n++; end while (!bus.ramWEN && n < 10);
        check("wb_started", {31'b0, bus.ramWEN}, 32'd1);
        check("wb_addr", bus.ramaddr, 32'h100);
        nRST = 1'b0;
        #1;
        check("arst_ramWEN",   {31'b0, bus.ramWEN}, 32'd0);
        check("arst_ramREN",   {31'b0, bus.ramREN}, 32'd0);
        check("arst_ramaddr",  bus.ramaddr,         32'd0);
        check("arst_ramstore", bus.ramstore,        32'd0);
        check("arst_dhit",     {31'b0, bus.dhit},   32'd0);
        bus.dmemREN = 1'b0;
`ifdef DCACHE_STATS_EN
        check("arst_hit_count",  hit_count,  32'd0);
        check("arst_miss_count", miss_count, 32'd0);
`endif
        @(negedge CLK);
        nRST = 1'b1;
        doReq(1, 0, 32'h100, 0, 32'h5A5A_0100, cyc, rc, wc, wbA, wbD, alA);
        check("post_rst_latency", cyc, 4);
        check("post_rst_ren", rc, 3);
        check("post_rst_wen", wc, 0);
`ifdef DCACHE_STATS_EN
        check("post_rst_hit_count",  hit_count,  32'd1);
        check("post_rst_miss_count", miss_count, 32'd1);
`endif

        check("ram_req_overlap", overlaps, 0);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
